// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREG   = 32;

    // One writeback request as seen by the arbiter.
    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wbReq_t;

    // Requester identity, also used as the round-robin last-grant pointer.
    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wbReqId_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request channel (valid/addr/data with a ready return).
// Latency: n/a (wires only).
// Backpressure: ready low means the requester must hold valid/addr/data.
// Ports: valid, addr, data driven by the requester; ready driven by the arbiter.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) ();

    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, addr, data, input ready);
    modport slave  (input valid, addr, data, output ready);

endinterface

// File: rtl/regfile_wb_arbiter_wb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at commit.
// Latency: pending updates at the clock edge; hazard/bypass lookups are combinational.
// Backpressure: none; decode stalls on hazardN and must not double-issue a pending register.
// Ports: issue*, commit* (output-stage write), chkAddr1/2 lookups, hazard1/2, pending,
// byp*Hit/byp*Data when built with WB_BYPASS_EN.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREG   = RF_NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic [ADDR_W-1:0] issueAddr,
    input  logic              commitVld,
    input  logic [ADDR_W-1:0] commitAddr,
`ifdef WB_BYPASS_EN
    input  logic [DATA_W-1:0] commitData,
    output logic              byp1Hit,
    output logic              byp2Hit,
    output logic [DATA_W-1:0] byp1Data,
    output logic [DATA_W-1:0] byp2Data,
`endif
    input  logic [ADDR_W-1:0] chkAddr1,
    input  logic [ADDR_W-1:0] chkAddr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic [NREG-1:0]   pending
);

    logic [NREG-1:0] pendingNxt;

    // Clear first, then set: an issue to the register being committed
    // belongs to a newer producer, so its bit must survive.
    always_comb begin
        pendingNxt = pending;
        if (commitVld) begin
            pendingNxt[commitAddr] = 1'b0;
        end
        if (issueValid && issueAddr != '0) begin
            pendingNxt[issueAddr] = 1'b1;
        end
        pendingNxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pendingNxt;
        end
    end

`ifdef WB_BYPASS_EN
    // The value being written this cycle can be forwarded straight to decode,
    // which removes the one-cycle hazard window before the pending bit clears.
    assign byp1Hit  = commitVld && commitAddr == chkAddr1 && chkAddr1 != '0;
    assign byp2Hit  = commitVld && commitAddr == chkAddr2 && chkAddr2 != '0;
    assign byp1Data = commitData;
    assign byp2Data = commitData;
    assign hazard1  = pending[chkAddr1] && chkAddr1 != '0 && !byp1Hit;
    assign hazard2  = pending[chkAddr2] && chkAddr2 != '0 && !byp2Hit;
`else
    assign hazard1  = pending[chkAddr1] && chkAddr1 != '0;
    assign hazard2  = pending[chkAddr2] && chkAddr2 != '0;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writebacks,
// plus the pending-write scoreboard. Optional forwarding is built with WB_BYPASS_EN.
// Latency: transfer at edge N drives rf_regWrite during cycle N+1.
// Backpressure: ready is combinational (grant, gated by reset); the loser holds its request.
// Ports: clk, rst (async active-low); aluIf/memIf request channels; issue_*/chk_addr* scoreboard
// access; hazard1/2, pending; rf_regWrite/rf_writeAddr/rf_writeData; byp* with WB_BYPASS_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREG   = RF_NREG
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_wb_arbiter_if.slave      aluIf,
    regfile_wb_arbiter_if.slave      memIf,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic [ADDR_W-1:0]        chk_addr1,
    input  logic [ADDR_W-1:0]        chk_addr2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic [NREG-1:0]          pending,
`ifdef WB_BYPASS_EN
    output logic                     byp1_hit,
    output logic                     byp2_hit,
    output logic [DATA_W-1:0]        byp1_data,
    output logic [DATA_W-1:0]        byp2_data,
`endif
    output logic                     rf_regWrite,
    output logic [ADDR_W-1:0]        rf_writeAddr,
    output logic [DATA_W-1:0]        rf_writeData
);

    wbReq_t   aluReq;
    wbReq_t   memReq;
    wbReq_t   winReq;
    wbReqId_e lastGrant;
    logic     aluGnt;
    logic     memGnt;

    // On a tie the requester that did not win last time goes first.
    // winReq.valid doubles as "a transfer happens this cycle".
    always_comb begin
        aluReq = '{valid: aluIf.valid, addr: aluIf.addr, data: aluIf.data};
        memReq = '{valid: memIf.valid, addr: memIf.addr, data: memIf.data};
        aluGnt = aluReq.valid && (!memReq.valid || lastGrant == WB_MEM);
        memGnt = memReq.valid && (!aluReq.valid || lastGrant == WB_ALU);
        winReq = '0;
        if (aluGnt) begin
            winReq = aluReq;
        end
        if (memGnt) begin
            winReq = memReq;
        end
    end

    // Reset forces ready low so nothing is accepted while state is being cleared.
    assign aluIf.ready = rst && aluGnt;
    assign memIf.ready = rst && memGnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant    <= WB_MEM;
            rf_regWrite  <= 1'b0;
            rf_writeAddr <= '0;
            rf_writeData <= '0;
        end else begin
            rf_regWrite <= 1'b0;
            if (winReq.valid) begin
                lastGrant    <= memGnt ? WB_MEM : WB_ALU;
                // Writes to r0 are accepted and dropped here.
                rf_regWrite  <= winReq.addr != '0;
                rf_writeAddr <= winReq.addr;
                rf_writeData <= winReq.data;
            end
        end
    end

    wb_scoreboard #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) uScoreboard (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issue_valid),
        .issueAddr  (issue_addr),
        .commitVld  (rf_regWrite),
        .commitAddr (rf_writeAddr),
`ifdef WB_BYPASS_EN
        .commitData (rf_writeData),
        .byp1Hit    (byp1_hit),
        .byp2Hit    (byp2_hit),
        .byp1Data   (byp1_data),
        .byp2Data   (byp2_data),
`endif
        .chkAddr1   (chk_addr1),
        .chkAddr2   (chk_addr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .pending    (pending)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round-robin contention, r0 writes,
// scoreboard set/clear and same-cycle set/clear priority, and forwarding when WB_BYPASS_EN is set.
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        hazard1;
    logic        hazard2;
    logic [31:0] pending;
    logic        rf_regWrite;
    logic [4:0]  rf_writeAddr;
    logic [31:0] rf_writeData;
`ifdef WB_BYPASS_EN
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp1_data;
    logic [31:0] byp2_data;
`endif

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if aluIf ();
    regfile_wb_arbiter_if memIf ();

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .aluIf        (aluIf),
        .memIf        (memIf),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .chk_addr1    (chk_addr1),
        .chk_addr2    (chk_addr2),
        .hazard1      (hazard1),
        .hazard2      (hazard2),
        .pending      (pending),
`ifdef WB_BYPASS_EN
        .byp1_hit     (byp1_hit),
        .byp2_hit     (byp2_hit),
        .byp1_data    (byp1_data),
        .byp2_data    (byp2_data),
`endif
        .rf_regWrite  (rf_regWrite),
        .rf_writeAddr (rf_writeAddr),
        .rf_writeData (rf_writeData)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge to the input-drive point.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Contention vectors: each requester's queued writes and the expected per-cycle result.
    logic [4:0]  aluAddrs [3] = '{5'd10, 5'd12, 5'd14};
    logic [31:0] aluDatas [3] = '{32'hA0, 32'hA2, 32'hA4};
    logic [4:0]  memAddrs [3] = '{5'd11, 5'd13, 5'd15};
    logic [31:0] memDatas [3] = '{32'hB1, 32'hB3, 32'hB5};
    logic        expAluRdy[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        expMemRdy[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [4:0]  expAddr  [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
    logic [31:0] expData  [4] = '{32'hA0, 32'hB1, 32'hA2, 32'hB3};

    initial begin
        int  ai;
        int  mi;
        logic aluRdySeen;
        logic memRdySeen;

        issue_valid = 1'b0;
        issue_addr  = '0;
        chk_addr1   = 5'd3;
        chk_addr2   = '0;
        aluIf.valid = 1'b1;
        aluIf.addr  = 5'd3;
        aluIf.data  = 32'hDEADBEEF;
        memIf.valid = 1'b0;
        memIf.addr  = '0;
        memIf.data  = '0;

        // Power-up reset, applied before the first clock edge.
        #1 rst = 1'b0;
        #1;
        checkVal("rst_alu_ready", 32'(aluIf.ready), 32'd0);
        checkVal("rst_regWrite", 32'(rf_regWrite), 32'd0);
        checkVal("rst_writeAddr", 32'(rf_writeAddr), 32'd0);
        checkVal("rst_writeData", rf_writeData, 32'd0);
        checkVal("rst_pending", pending, 32'd0);
        checkVal("rst_hazard1", 32'(hazard1), 32'd0);
        step();
        step();

        // Release between edges; the held ALU request is accepted at the next edge.
        rst = 1'b1;
        #1;
        checkVal("first_alu_ready", 32'(aluIf.ready), 32'd1);
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        step();
        aluIf.valid = 1'b0;
        issue_valid = 1'b0;
        checkVal("first_regWrite", 32'(rf_regWrite), 32'd1);
        checkVal("first_writeAddr", 32'(rf_writeAddr), 32'd3);
        checkVal("first_writeData", rf_writeData, 32'hDEADBEEF);
        step();
        checkVal("idle_regWrite", 32'(rf_regWrite), 32'd0);
        checkVal("idle_addr_hold", 32'(rf_writeAddr), 32'd3);
        checkVal("idle_data_hold", rf_writeData, 32'hDEADBEEF);
        checkVal("issue5_pending", pending, 32'h0000_0020);

        // Reset mid-stream, while a write is on the output stage.
        aluIf.valid = 1'b1;
        aluIf.addr  = 5'd4;
        aluIf.data  = 32'h1;
        step();
        aluIf.valid = 1'b0;
        memIf.valid = 1'b1;
        memIf.addr  = 5'd6;
        #1 rst = 1'b0;
        #1;
        checkVal("mid_rst_regWrite", 32'(rf_regWrite), 32'd0);
        checkVal("mid_rst_writeAddr", 32'(rf_writeAddr), 32'd0);
        checkVal("mid_rst_writeData", rf_writeData, 32'd0);
        checkVal("mid_rst_pending", pending, 32'd0);
        checkVal("mid_rst_mem_ready", 32'(memIf.ready), 32'd0);
        memIf.valid = 1'b0;
        rst = 1'b1;
        step();

        // Contention: both valid every cycle; ALU wins the first tie after reset.
        ai = 0;
        mi = 0;
        for (int c = 0; c < 4; c++) begin
            aluIf.valid = 1'b1;
            aluIf.addr  = aluAddrs[ai];
            aluIf.data  = aluDatas[ai];
            memIf.valid = 1'b1;
            memIf.addr  = memAddrs[mi];
            memIf.data  = memDatas[mi];
            #1;
            aluRdySeen = aluIf.ready;
            memRdySeen = memIf.ready;
            checkVal($sformatf("cont%0d_alu_ready", c), 32'(aluRdySeen), 32'(expAluRdy[c]));
            checkVal($sformatf("cont%0d_mem_ready", c), 32'(memRdySeen), 32'(expMemRdy[c]));
            step();
            checkVal($sformatf("cont%0d_regWrite", c), 32'(rf_regWrite), 32'd1);
            checkVal($sformatf("cont%0d_writeAddr", c), 32'(rf_writeAddr), 32'(expAddr[c]));
            checkVal($sformatf("cont%0d_writeData", c), rf_writeData, expData[c]);
            if (aluRdySeen) ai++;
            if (memRdySeen) mi++;
        end
        aluIf.valid = 1'b0;
        memIf.valid = 1'b0;

        // Zero register: accepted, no write, no pending bit.
        memIf.valid = 1'b1;
        memIf.addr  = 5'd0;
        memIf.data  = 32'h1234;
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        #1;
        checkVal("zero_mem_ready", 32'(memIf.ready), 32'd1);
        step();
        memIf.valid = 1'b0;
        issue_valid = 1'b0;
        checkVal("zero_regWrite", 32'(rf_regWrite), 32'd0);
        checkVal("zero_pending", pending, 32'd0);

        // Scoreboard set by issue, cleared by the commit edge.
        issue_valid = 1'b1;
        issue_addr  = 5'd5;
        step();
        issue_valid = 1'b0;
        chk_addr1   = 5'd5;
        chk_addr2   = 5'd6;
        #1;
        checkVal("sb5_pending", pending, 32'h0000_0020);
        checkVal("sb5_hazard1", 32'(hazard1), 32'd1);
        checkVal("sb5_hazard2", 32'(hazard2), 32'd0);
        aluIf.valid = 1'b1;
        aluIf.addr  = 5'd5;
        aluIf.data  = 32'h55;
        step();
        aluIf.valid = 1'b0;
        #1;
        checkVal("sb5_commit_regWrite", 32'(rf_regWrite), 32'd1);
        checkVal("sb5_commit_pending", pending, 32'h0000_0020);
`ifdef WB_BYPASS_EN
        checkVal("sb5_commit_hazard1", 32'(hazard1), 32'd0);
`else
        checkVal("sb5_commit_hazard1", 32'(hazard1), 32'd1);
`endif
        step();
        checkVal("sb5_cleared_pending", pending, 32'd0);
        checkVal("sb5_cleared_hazard1", 32'(hazard1), 32'd0);

        // Same-cycle set and clear on r7: set wins.
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        step();
        issue_valid = 1'b0;
        aluIf.valid = 1'b1;
        aluIf.addr  = 5'd7;
        aluIf.data  = 32'h77;
        step();
        aluIf.valid = 1'b0;
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        checkVal("same_commit_regWrite", 32'(rf_regWrite), 32'd1);
        step();
        issue_valid = 1'b0;
        chk_addr2   = 5'd7;
        #1;
        checkVal("same_pending", pending, 32'h0000_0080);
        checkVal("same_hazard2", 32'(hazard2), 32'd1);

        // Commit cycle for r9 while decode reads r9 on port 2.
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        step();
        issue_valid = 1'b0;
        aluIf.valid = 1'b1;
        aluIf.addr  = 5'd9;
        aluIf.data  = 32'hA5A5A5A5;
        chk_addr2   = 5'd9;
        step();
        aluIf.valid = 1'b0;
        #1;
        checkVal("r9_commit_pending", pending, 32'h0000_0280);
`ifdef WB_BYPASS_EN
        checkVal("r9_byp2_hit", 32'(byp2_hit), 32'd1);
        checkVal("r9_byp2_data", byp2_data, 32'hA5A5A5A5);
        checkVal("r9_byp1_hit", 32'(byp1_hit), 32'd0);
        checkVal("r9_hazard2", 32'(hazard2), 32'd0);
`else
        checkVal("r9_hazard2", 32'(hazard2), 32'd1);
`endif
        step();
        checkVal("r9_after_pending", pending, 32'h0000_0080);
        checkVal("r9_after_hazard2", 32'(hazard2), 32'd0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
